// File: rtl/video_timing_aligner_if.sv
// Signal bundle between the video timing aligner and its neighbours.
// Upstream sees undelayed counters and supplies mode and stage pixels;
// downstream consumes the aligned pixel/sync/enable stream.
// Handshake: none. The stream never stalls; de is the only qualifier, and
// pixel carries display data exactly on cycles where de=1 (BORDER otherwise).
interface video_timing_aligner_if #(
  parameter int NUM_MODES = 6,
  parameter int PIX_W     = 12
);
  logic [3:0]                 mode;
  logic [NUM_MODES*PIX_W-1:0] stage_pix;
  logic [10:0]                hcount;
  logic [10:0]                vcount;
  logic [PIX_W-1:0]           pixel;
  logic                       hs;
  logic                       vs;
  logic                       de;
  logic                       frame_start;
  logic [3:0]                 mode_active;

  // The aligner itself.
  modport master (
    input  mode, stage_pix,
    output hcount, vcount, pixel, hs, vs, de, frame_start, mode_active
  );

  // Whoever drives mode/stage pixels and consumes the aligned stream.
  modport slave (
    output mode, stage_pix,
    input  hcount, vcount, pixel, hs, vs, de, frame_start, mode_active
  );
endinterface

// File: rtl/video_timing_aligner.sv
// Video timing generator with a per-mode latency-matched sync/enable path.
// The counters run undelayed for upstream addressing; hs/vs/de are delayed by
// the latency of the currently selected processing stage so they line up with
// that stage's pixel output. Mode changes apply only at frame boundaries and
// blank the output for MAX_LAT+1 cycles while the pipeline refills.
// MAX_LAT must be at least 1.
module video_timing_aligner #(
  parameter int                     H_BLANK   = 256,
  parameter int                     H_ACTIVE  = 800,
  parameter int                     H_SYNC    = 128,
  parameter int                     V_BLANK   = 28,
  parameter int                     V_ACTIVE  = 600,
  parameter int                     V_SYNC    = 4,
  parameter int                     NUM_MODES = 6,
  parameter int                     PIX_W     = 12,
  parameter int                     MAX_LAT   = 31,
  parameter logic [NUM_MODES*8-1:0] LAT_TABLE = '0,
  parameter logic [PIX_W-1:0]       BORDER    = PIX_W'(12'h111)
) (
  input logic                    clk,
  input logic                    rst,
  video_timing_aligner_if.master bus
);
  localparam int         H_TOTAL   = H_BLANK + H_ACTIVE;
  localparam int         V_TOTAL   = V_BLANK + V_ACTIVE;
  localparam int         GW        = $clog2(MAX_LAT + 2);
  localparam logic [7:0] MAX_LAT_B = 8'(MAX_LAT);

  logic [10:0]      hcount;
  logic [10:0]      vcount;
  logic             h_last;
  logic             v_last;
  logic             frame_last;
  logic             hs_raw;
  logic             vs_raw;
  logic             de_raw;
  logic [3:0]       mode_active;
  logic [3:0]       mode_next;
  logic [GW-1:0]    guard;
  logic             guard_idle;
  logic [7:0]       lat;
  logic [PIX_W-1:0] sel_pix;
  logic [MAX_LAT-1:0] sr_hs;
  logic [MAX_LAT-1:0] sr_vs;
  logic [MAX_LAT-1:0] sr_de;
  logic [MAX_LAT:0] tap_hs_v;
  logic [MAX_LAT:0] tap_vs_v;
  logic [MAX_LAT:0] tap_de_v;
  logic             tap_hs;
  logic             tap_vs;
  logic             tap_de;
  logic             hs_q;
  logic             vs_q;
  logic             de_q;
  logic [PIX_W-1:0] pixel_q;

  assign h_last     = (hcount == 11'(H_TOTAL - 1));
  assign v_last     = (vcount == 11'(V_TOTAL - 1));
  assign frame_last = h_last && v_last;

  assign hs_raw = (hcount >= 11'(H_SYNC));
  assign vs_raw = (vcount >= 11'(V_SYNC));
  assign de_raw = (hcount >= 11'(H_BLANK)) && (vcount >= 11'(V_BLANK));

  // Unsupported modes fall back to the pass-through channel 0.
  assign mode_next  = (int'(bus.mode) >= NUM_MODES) ? 4'd0 : bus.mode;
  assign guard_idle = (guard == '0);

  // Tap 0 is the raw value itself, tap i is the raw value i cycles old.
  assign tap_hs_v = {sr_hs, hs_raw};
  assign tap_vs_v = {sr_vs, vs_raw};
  assign tap_de_v = {sr_de, de_raw};

  // Free-running raster counters; a reset abandons the frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (h_last) begin
      hcount <= '0;
      vcount <= v_last ? 11'd0 : vcount + 11'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  // Mode is latched only on the last pixel of a frame; a real change arms the guard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_active <= '0;
      guard       <= '0;
    end else begin
      if (frame_last) begin
        mode_active <= mode_next;
      end
      if (frame_last && (mode_next != mode_active)) begin
        guard <= GW'(MAX_LAT + 1);
      end else if (!guard_idle) begin
        guard <= guard - GW'(1);
      end
    end
  end

  // Raw-timing history; the reset contents look like idle blanking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_hs <= '1;
      sr_vs <= '1;
      sr_de <= '0;
    end else begin
      sr_hs[0] <= hs_raw;
      sr_vs[0] <= vs_raw;
      sr_de[0] <= de_raw;
      for (int i = 1; i < MAX_LAT; i++) begin
        sr_hs[i] <= sr_hs[i-1];
        sr_vs[i] <= sr_vs[i-1];
        sr_de[i] <= sr_de[i-1];
      end
    end
  end

  // Look up the active mode's latency (saturated) and its stage pixel.
  always_comb begin
    lat     = 8'd0;
    sel_pix = BORDER;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (int'(mode_active) == m) begin
        lat     = LAT_TABLE[8*m +: 8];
        sel_pix = bus.stage_pix[PIX_W*m +: PIX_W];
      end
    end
    if (lat > MAX_LAT_B) begin
      lat = MAX_LAT_B;
    end
  end

  // Select the delay-line tap matching the current latency.
  always_comb begin
    tap_hs = 1'b1;
    tap_vs = 1'b1;
    tap_de = 1'b0;
    for (int i = 0; i <= MAX_LAT; i++) begin
      if (int'(lat) == i) begin
        tap_hs = tap_hs_v[i];
        tap_vs = tap_vs_v[i];
        tap_de = tap_de_v[i];
      end
    end
  end

  // Output register; the guard blanks de/pixel but lets sync keep running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      de_q    <= 1'b0;
      pixel_q <= BORDER;
    end else begin
      hs_q    <= tap_hs;
      vs_q    <= tap_vs;
      de_q    <= tap_de && guard_idle;
      pixel_q <= (tap_de && guard_idle) ? sel_pix : BORDER;
    end
  end

  assign bus.hcount      = hcount;
  assign bus.vcount      = vcount;
  assign bus.frame_start = (hcount == 11'd0) && (vcount == 11'd0);
  assign bus.mode_active = mode_active;
  assign bus.hs          = hs_q;
  assign bus.vs          = vs_q;
  assign bus.de          = de_q;
  assign bus.pixel       = pixel_q;
endmodule
